// File: rtl/ram_seq_engine_if.sv
// Bundles the command handshake and RAM port of ram_seq_engine.
// master = engine side, slave = control logic / RAM side.
interface ram_seq_engine_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 64
);
   logic          start;
   logic [1:0]    op;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW:0]   len;
   logic [DW-1:0] pattern;
   logic          busy;
   logic          done;
   logic [AW:0]   err_cnt;
   logic          ram_cen;
   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport master (
      input  start, op, src, dst, len, pattern, ram_dout,
      output busy, done, err_cnt, ram_cen, ram_wen, ram_addr, ram_din
   );

   modport slave (
      output start, op, src, dst, len, pattern, ram_dout,
      input  busy, done, err_cnt, ram_cen, ram_wen, ram_addr, ram_din
   );
endinterface

// File: rtl/ram_seq_engine.sv
// Block command engine (FILL / COPY / CHECK) driving a single-port
// synchronous RAM with registered read data.
module ram_seq_engine #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ram_seq_engine_if.master     bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_COPY_RD, S_COPY_WR, S_CHK, S_CHK_DRAIN, S_DONE
   } state_t;

   localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE     = (AW+1)'(1);

   state_t        state, state_nx;
   logic [AW-1:0] src_r, dst_r;
   logic [AW:0]   len_r, idx, err_r, len_eff;
   logic [DW-1:0] pat_r;
   logic          last, mismatch;

   logic          cen, wen;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;

   always_comb len_eff = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
   always_comb last     = (idx == len_r - ONE);
   always_comb mismatch = (bus.ram_dout != pat_r);

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cen      = 1'b0;
      wen      = 1'b0;
      addr     = '0;
      din      = '0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (len_eff == '0 || bus.op == 2'b11) state_nx = S_DONE;
               else if (bus.op == 2'b00)             state_nx = S_FILL;
               else if (bus.op == 2'b01)             state_nx = S_COPY_RD;
               else                                  state_nx = S_CHK;
            end
         end
         S_FILL: begin
            cen  = 1'b1;
            wen  = 1'b1;
            addr = dst_r + idx[AW-1:0];
            din  = pat_r;
            if (last) state_nx = S_DONE;
         end
         S_COPY_RD: begin
            cen      = 1'b1;
            addr     = src_r + idx[AW-1:0];
            state_nx = S_COPY_WR;
         end
         S_COPY_WR: begin
            // Read data arrives this cycle and is written straight back out.
            cen      = 1'b1;
            wen      = 1'b1;
            addr     = dst_r + idx[AW-1:0];
            din      = bus.ram_dout;
            state_nx = last ? S_DONE : S_COPY_RD;
         end
         S_CHK: begin
            cen  = 1'b1;
            addr = dst_r + idx[AW-1:0];
            if (last) state_nx = S_CHK_DRAIN;
         end
         S_CHK_DRAIN: state_nx = S_DONE;
         S_DONE:      state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         src_r <= '0;
         dst_r <= '0;
         len_r <= '0;
         pat_r <= '0;
         idx   <= '0;
         err_r <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  src_r <= bus.src;
                  dst_r <= bus.dst;
                  len_r <= len_eff;
                  pat_r <= bus.pattern;
                  idx   <= '0;
                  err_r <= '0;
               end
            end
            S_FILL, S_COPY_WR: idx <= idx + ONE;
            S_CHK: begin
               // Data for word idx-1 is on ram_dout; word 0 has not arrived yet.
               idx <= idx + ONE;
               if (idx != '0 && mismatch) err_r <= err_r + ONE;
            end
            S_CHK_DRAIN: if (mismatch) err_r <= err_r + ONE;
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_DONE);
   assign bus.err_cnt  = err_r;
   assign bus.ram_cen  = cen;
   assign bus.ram_wen  = wen;
   assign bus.ram_addr = addr;
   assign bus.ram_din  = din;
endmodule

// File: tb/tb_ram_seq_engine.sv
// Directed bench for ram_seq_engine with a behavioural 256 x 64 RAM model.
module tb_ram_seq_engine;
   localparam logic [63:0] PA   = 64'hA5A5_A5A5_A5A5_A5A5;
   localparam logic [63:0] P2   = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] P3   = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] P4   = 64'h5A5A_0000_FFFF_1234;
   localparam logic [63:0] INIT = 64'h1111_0000_0000_0000;

   logic clk = 1'b0;
   logic reset_n;
   logic mem_init;
   logic [63:0] mem [0:255];

   int checks = 0;
   int failures = 0;

   logic       rec_cen  [0:599];
   logic       rec_wen  [0:599];
   logic [7:0] rec_addr [0:599];
   logic       rec_busy [0:599];
   int done_cyc, done_cnt, ncen, nwr;

   ram_seq_engine_if #(.AW(8), .DW(64)) bus ();

   ram_seq_engine #(.AW(8), .DW(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int unsigned k = 0; k < 256; k++) mem[k] <= INIT + 64'(k);
         bus.ram_dout <= '0;
      end else if (bus.ram_cen) begin
         if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_din;
         else             bus.ram_dout <= mem[bus.ram_addr];
      end else begin
         bus.ram_dout <= '0;
      end
   end

   // Issues one command and records per-cycle RAM activity; cycle c is the c-th cycle after E0.
   task automatic run_cmd(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] l, input logic [63:0] p, input int pulse_at);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.src = s; bus.dst = d; bus.len = l; bus.pattern = p;
      done_cyc = -1; done_cnt = 0; ncen = 0; nwr = 0;
      for (int c = 1; c < 600; c++) begin
         @(negedge clk);
         rec_cen[c] = bus.ram_cen; rec_wen[c] = bus.ram_wen;
         rec_addr[c] = bus.ram_addr; rec_busy[c] = bus.busy;
         if (bus.ram_cen) ncen++;
         if (bus.ram_cen && bus.ram_wen) nwr++;
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c == 1) begin
            bus.start = 1'b0; bus.op = 2'b00; bus.src = 8'hC0; bus.dst = 8'hC0;
            bus.len = 9'd1; bus.pattern = '1;
         end
         if (c == pulse_at)     bus.start = 1'b1;
         if (c == pulse_at + 1) bus.start = 1'b0;
         if (done_cyc > 0 && c >= done_cyc + 4) break;
      end
   endtask

   task automatic test_reset;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
      checks++; if (bus.err_cnt !== 9'd0) begin failures++; $display("FAIL reset_err: got %0d expected 0", bus.err_cnt); end
      checks++;
      if ({bus.ram_cen, bus.ram_wen, bus.ram_addr, bus.ram_din} !== 74'd0) begin
         failures++;
         $display("FAIL reset_ram: got cen=%0b wen=%0b addr=%0h din=%0h expected all 0",
                  bus.ram_cen, bus.ram_wen, bus.ram_addr, bus.ram_din);
      end
   endtask

   task automatic test_fill;
      logic [7:0] ea;
      run_cmd(2'b00, 8'h00, 8'h10, 9'd4, PA, 0);
      checks++; if (done_cyc != 5) begin failures++; $display("FAIL fill_done: got %0d expected 5", done_cyc); end
      checks++; if (nwr != 4 || ncen != 4) begin failures++; $display("FAIL fill_count: got cen=%0d wr=%0d expected 4/4", ncen, nwr); end
      checks++; if (rec_busy[1] !== 1'b1 || rec_busy[6] !== 1'b0) begin failures++; $display("FAIL fill_busy: got c1=%0b c6=%0b expected 1/0", rec_busy[1], rec_busy[6]); end
      for (int c = 1; c <= 4; c++) begin
         ea = 8'h10 + 8'(c - 1);
         checks++;
         if (rec_cen[c] !== 1'b1 || rec_wen[c] !== 1'b1 || rec_addr[c] !== ea) begin
            failures++;
            $display("FAIL fill_access c%0d: got cen=%0b wen=%0b addr=%0h expected 1/1/%0h", c, rec_cen[c], rec_wen[c], rec_addr[c], ea);
         end
         checks++; if (mem[ea] !== PA) begin failures++; $display("FAIL fill_mem %0h: got %0h expected %0h", ea, mem[ea], PA); end
      end
      checks++; if (mem[8'h14] !== INIT + 64'h14) begin failures++; $display("FAIL fill_over: got %0h expected %0h", mem[8'h14], INIT + 64'h14); end
   endtask

   task automatic test_copy;
      logic [7:0] ea;
      run_cmd(2'b01, 8'h10, 8'h80, 9'd4, '0, 0);
      checks++; if (done_cyc != 9) begin failures++; $display("FAIL copy_done: got %0d expected 9", done_cyc); end
      checks++; if (ncen != 8 || nwr != 4) begin failures++; $display("FAIL copy_count: got cen=%0d wr=%0d expected 8/4", ncen, nwr); end
      for (int c = 1; c <= 8; c++) begin
         ea = ((c % 2) == 1) ? 8'h10 + 8'((c - 1) / 2) : 8'h80 + 8'((c - 1) / 2);
         checks++;
         if (rec_cen[c] !== 1'b1 || rec_wen[c] !== ((c % 2) == 0) || rec_addr[c] !== ea) begin
            failures++;
            $display("FAIL copy_access c%0d: got wen=%0b addr=%0h expected wen=%0b addr=%0h", c, rec_wen[c], rec_addr[c], (c % 2) == 0, ea);
         end
      end
      for (int unsigned k = 8'h80; k <= 8'h83; k++) begin
         checks++; if (mem[k] !== PA) begin failures++; $display("FAIL copy_mem %0h: got %0h expected %0h", k, mem[k], PA); end
      end
      checks++; if (mem[8'h84] !== INIT + 64'h84) begin failures++; $display("FAIL copy_over: got %0h expected %0h", mem[8'h84], INIT + 64'h84); end
   endtask

   task automatic test_check;
      run_cmd(2'b10, 8'h00, 8'h80, 9'd4, PA, 0);
      checks++; if (done_cyc != 6) begin failures++; $display("FAIL chk_done: got %0d expected 6", done_cyc); end
      checks++; if (bus.err_cnt !== 9'd0) begin failures++; $display("FAIL chk_err0: got %0d expected 0", bus.err_cnt); end
      checks++; if (ncen != 4 || nwr != 0) begin failures++; $display("FAIL chk_count: got cen=%0d wr=%0d expected 4/0", ncen, nwr); end
      run_cmd(2'b00, 8'h00, 8'h82, 9'd1, '0, 0);
      run_cmd(2'b10, 8'h00, 8'h80, 9'd4, PA, 0);
      checks++; if (bus.err_cnt !== 9'd1) begin failures++; $display("FAIL chk_err1: got %0d expected 1", bus.err_cnt); end
      run_cmd(2'b10, 8'h00, 8'h80, 9'd4, '0, 0);
      checks++; if (bus.err_cnt !== 9'd3) begin failures++; $display("FAIL chk_err3: got %0d expected 3", bus.err_cnt); end
   endtask

   task automatic test_zero;
      run_cmd(2'b00, 8'h00, 8'h20, 9'd0, PA, 0);
      checks++; if (done_cyc != 1 || ncen != 0) begin failures++; $display("FAIL len0: got done=%0d cen=%0d expected 1/0", done_cyc, ncen); end
      checks++; if (bus.err_cnt !== 9'd0) begin failures++; $display("FAIL len0_err: got %0d expected 0", bus.err_cnt); end
      run_cmd(2'b11, 8'h00, 8'h20, 9'd5, PA, 0);
      checks++; if (done_cyc != 1 || ncen != 0 || done_cnt != 1) begin failures++; $display("FAIL op3: got done=%0d cen=%0d pulses=%0d expected 1/0/1", done_cyc, ncen, done_cnt); end
   endtask

   task automatic test_back_to_back;
      run_cmd(2'b01, 8'h80, 8'h40, 9'd4, '0, 3);
      checks++; if (done_cyc != 9 || done_cnt != 1) begin failures++; $display("FAIL busy_start: got done=%0d pulses=%0d expected 9/1", done_cyc, done_cnt); end
      checks++; if (ncen != 8) begin failures++; $display("FAIL busy_start_cen: got %0d expected 8", ncen); end
      checks++;
      if (mem[8'h40] !== PA || mem[8'h41] !== PA || mem[8'h42] !== 64'd0 || mem[8'h43] !== PA) begin
         failures++;
         $display("FAIL busy_start_mem: got %0h %0h %0h %0h expected A5,A5,0,A5", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01; bus.src = 8'h10; bus.dst = 8'hA0; bus.len = 9'd4; bus.pattern = '0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ram_cen !== 1'b0 || bus.err_cnt !== 9'd0) begin
         failures++;
         $display("FAIL reset_mid: got busy=%0b done=%0b cen=%0b err=%0d expected 0", bus.busy, bus.done, bus.ram_cen, bus.err_cnt);
      end
      reset_n = 1'b1;
      checks++;
      if (mem[8'hA1] !== PA || mem[8'hA2] !== INIT + 64'hA2) begin
         failures++;
         $display("FAIL reset_mid_mem: got %0h %0h expected %0h %0h", mem[8'hA1], mem[8'hA2], PA, INIT + 64'hA2);
      end
      run_cmd(2'b00, 8'h00, 8'h30, 9'd2, P4, 0);
      checks++; if (done_cyc != 3 || mem[8'h31] !== P4) begin failures++; $display("FAIL reset_mid_fill: got done=%0d mem=%0h expected 3/%0h", done_cyc, mem[8'h31], P4); end
   endtask

   task automatic test_wrap;
      logic [7:0] exp_a [0:3];
      exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
      run_cmd(2'b00, 8'h00, 8'hFE, 9'd4, P2, 0);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (rec_addr[c] !== exp_a[c-1] || mem[exp_a[c-1]] !== P2) begin
            failures++;
            $display("FAIL wrap c%0d: got addr=%0h mem=%0h expected %0h/%0h", c, rec_addr[c], mem[exp_a[c-1]], exp_a[c-1], P2);
         end
      end
      run_cmd(2'b00, 8'h00, 8'h00, 9'd256, P3, 0);
      checks++; if (done_cyc != 257 || nwr != 256) begin failures++; $display("FAIL fill256: got done=%0d wr=%0d expected 257/256", done_cyc, nwr); end
      checks++; if (mem[0] !== P3 || mem[255] !== P3) begin failures++; $display("FAIL fill256_mem: got %0h %0h expected %0h", mem[0], mem[255], P3); end
      run_cmd(2'b10, 8'h00, 8'h00, 9'd256, P3, 0);
      checks++; if (done_cyc != 258 || bus.err_cnt !== 9'd0) begin failures++; $display("FAIL chk256: got done=%0d err=%0d expected 258/0", done_cyc, bus.err_cnt); end
      run_cmd(2'b00, 8'h00, 8'h05, 9'd1, '0, 0);
      run_cmd(2'b10, 8'h00, 8'h10, 9'd300, P3, 0);
      checks++; if (done_cyc != 258 || bus.err_cnt !== 9'd1) begin failures++; $display("FAIL chk_clamp: got done=%0d err=%0d expected 258/1", done_cyc, bus.err_cnt); end
      checks++; if (rec_addr[256] !== 8'h0F) begin failures++; $display("FAIL chk_clamp_addr: got %0h expected 0f", rec_addr[256]); end
   endtask

   initial begin
      reset_n = 1'b0; mem_init = 1'b1;
      bus.start = 1'b0; bus.op = '0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.pattern = '0;
      repeat (3) @(negedge clk);
      test_reset;
      reset_n = 1'b1; mem_init = 1'b0;
      test_fill;
      test_copy;
      test_check;
      test_zero;
      test_back_to_back;
      test_reset_mid;
      test_wrap;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ram_seq_engine.md
# ram_seq_engine

Command-driven initiator for the 256 x 64-bit single-port synchronous RAM: it drives the RAM's chip-enable, write-enable, address and write-data pins and consumes its registered read data. It executes one block command at a time: FILL a range with a pattern, COPY a range, or CHECK a range against a pattern and count mismatches. It sits between control logic (start/done handshake) and the RAM port, so no other logic has to sequence RAM accesses directly.

## Interface
- AW, 8, RAM address width (256 words)
- DW, 64, RAM data width
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  command request; accepted only in IDLE
- op  in  2  00 FILL, 01 COPY, 10 CHECK, 11 reserved
- src  in  AW  COPY source base address
- dst  in  AW  FILL/CHECK base; COPY destination base
- len  in  AW+1  word count, 0..256; values >256 treated as 256
- pattern  in  DW  FILL write value / CHECK compare value
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- err_cnt  out  AW+1  CHECK mismatch count
- ram_cen  out  1  RAM chip enable
- ram_wen  out  1  RAM write enable (1 write, 0 read)
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data; valid the cycle after the read edge, forced to 0 by the RAM on any edge with ram_cen=0

## Operation
- States: IDLE, FILL, COPY_RD, COPY_WR, CHK, CHK_DRAIN, DONE.
- IDLE: start=1 at an edge latches op/src/dst/len/pattern, clears err_cnt and the word index i. Next state: DONE if effective len=0 or op=11, else FILL, COPY_RD or CHK.
- FILL: cen=1, wen=1, addr=dst+i, din=pattern; one word per cycle; after word len-1, go to DONE.
- COPY_RD: cen=1, wen=0, addr=src+i; go to COPY_WR.
- COPY_WR: cen=1, wen=1, addr=dst+i, din=ram_dout (combinational pass-through); increment i; go to COPY_RD, or to DONE after word len-1.
- CHK: cen=1, wen=0, addr=dst+i, one read per cycle. Each cycle after the first CHK cycle, compare ram_dout to pattern and increment err_cnt on mismatch. After issuing word len-1, go to CHK_DRAIN.
- CHK_DRAIN: cen=0; compare the last word; go to DONE.
- DONE: done=1, cen=0; go to IDLE.
- Address arithmetic is modulo 2^AW: base + i wraps 0xFF -> 0x00.
- COPY runs in ascending order, one word at a time. Overlapping ranges with dst>src replicate source data; this is intended.
- start while busy is ignored and not queued. Inputs may change freely after acceptance.
- Outside active states: ram_cen=0, ram_wen=0, ram_addr=0, ram_din=0.
- err_cnt holds its value after DONE until the next accepted command. err_cnt=0 for FILL, COPY and reserved ops.

## Timing
- Reset: reset_n=0 at an edge forces IDLE, busy=0, done=0, err_cnt=0, and all ram_* outputs to 0. It aborts any command mid-operation; words already written stay written.
- Accept edge = E0. First RAM access is driven in cycle 1 (after E0).
- FILL: access cycles 1..len; done in cycle len+1.
- COPY: 2*len access cycles; done in cycle 2*len+1.
- CHECK: len read cycles plus 1 drain cycle; done in cycle len+2. err_cnt is final when done=1.
- len=0 or op=11: done in cycle 1, no RAM access.
- busy rises in cycle 1 and falls in the cycle after done. A new start may be accepted on the edge that ends the done cycle's successor (IDLE).

## Test plan
- FILL dst=0x10 len=4 pattern=0xA5A5_A5A5_A5A5_A5A5 -> writes with cen=wen=1 at addr 0x10..0x13 in cycles 1-4; done in cycle 5; RAM readback equals pattern.
- COPY src=0x10 dst=0x80 len=4 after the fill -> alternating read 0x10+i / write 0x80+i over 8 cycles; done in cycle 9; mem[0x80..0x83]=0xA5A5_A5A5_A5A5_A5A5.
- CHECK dst=0x80 len=4 with the same pattern -> err_cnt=0, done in cycle 6. Then FILL dst=0x82 len=1 pattern=0, re-CHECK -> err_cnt=1.
- Wrap: FILL dst=0xFE len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01. Also len=256 from 0x00 -> 256 writes, done in cycle 257.
- len=0 and op=11 -> done in cycle 1, ram_cen never asserted. start pulsed mid-COPY -> ignored, no extra done pulse.
- reset_n=0 during COPY word 2 -> next edge: busy=0, done=0, ram_cen=0, err_cnt=0; the FSM then accepts a fresh FILL normally.
